// File: rtl/regfile_dump_pkg.sv
// Shared types and sizes for the register-file dumper.
// REGFILE_DUMP_CHECKSUM_EN adds the CSUM state.
package regfile_dump_pkg;

  localparam int REG_COUNT = 32;
  localparam int IDX_W     = 5;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = $clog2(REG_COUNT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_DRAIN,
`ifdef REGFILE_DUMP_CHECKSUM_EN
    S_DONE,
    S_CSUM
`else
    S_DONE
`endif
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } entry_t;

endpackage

// File: rtl/regfile_dump_buf.sv
// Two-entry ordered output buffer; entry 0 always drains before entry 1.
// Loading overwrites both entries at once.
module regfile_dump_buf
  import regfile_dump_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load,
  input  logic   two,
  input  entry_t in0,
  input  entry_t in1,
  input  logic   pop,
  output logic   valid,
  output logic   single,
  output entry_t head
);

  entry_t e0_q, e0_d;
  entry_t e1_q, e1_d;
  logic   v0_q, v0_d;
  logic   v1_q, v1_d;

  always_comb begin
    e0_d = e0_q;
    e1_d = e1_q;
    v0_d = v0_q;
    v1_d = v1_q;
    if (load) begin
      e0_d = in0;
      e1_d = two ? in1 : '0;
      v0_d = 1'b1;
      v1_d = two;
    end else if (pop) begin
      if (v0_q) v0_d = 1'b0;
      else      v1_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e0_q <= '0;
      e1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
    end
  end

  assign valid  = v0_q | v1_q;
  assign single = v0_q ^ v1_q;
  assign head   = v0_q ? e0_q : (v1_q ? e1_q : '0);

endmodule

// File: rtl/regfile_dumper.sv
// Dumps a wrapping range of the register file two words per read cycle.
// REGFILE_DUMP_CHECKSUM_EN appends an XOR checksum word.
module regfile_dumper
  import regfile_dump_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  first_index,
  input  logic [IDX_W-1:0]  last_index,
  output logic              rd_en1,
  output logic [IDX_W-1:0]  rd_index1,
  output logic              rd_en2,
  output logic [IDX_W-1:0]  rd_index2,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam bit LAST_ON = 1'b0;
`else
  localparam bit LAST_ON = 1'b1;
`endif

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] step;
  logic [IDX_W-1:0] diff;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
`endif

  logic   buf_load;
  logic   buf_two;
  logic   buf_pop;
  logic   buf_valid;
  logic   buf_single;
  entry_t buf_in0;
  entry_t buf_in1;
  entry_t buf_head;

  assign diff    = last_index - first_index;
  assign step    = (cnt_q >= CNT_W'(2)) ? CNT_W'(2) : CNT_W'(1);
  assign buf_two = cnt_q >= CNT_W'(2);

  // Data lands one cycle after READ; ptr/cnt are unchanged until drain
  assign buf_in0 = '{data: rd_data1, idx: ptr_q,
                     last: LAST_ON && (cnt_q == CNT_W'(1))};
  assign buf_in1 = '{data: rd_data2, idx: ptr_q + IDX_W'(1),
                     last: LAST_ON && (cnt_q == CNT_W'(2))};

  regfile_dump_buf u_obuf (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (buf_load),
    .two     (buf_two),
    .in0     (buf_in0),
    .in1     (buf_in1),
    .pop     (buf_pop),
    .valid   (buf_valid),
    .single  (buf_single),
    .head    (buf_head)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    acc_d     = acc_q;
`endif
    rd_en1    = 1'b0;
    rd_index1 = '0;
    rd_en2    = 1'b0;
    rd_index2 = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    buf_load  = 1'b0;
    buf_pop   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d   = first_index;
          cnt_d   = CNT_W'(diff) + CNT_W'(1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
          state_d = S_READ;
        end
      end
      S_READ: begin
        rd_en1    = 1'b1;
        rd_index1 = ptr_q;
        if (buf_two) begin
          rd_en2    = 1'b1;
          rd_index2 = ptr_q + IDX_W'(1);
        end
        state_d = S_CAPT;
      end
      S_CAPT: begin
        buf_load = 1'b1;
        state_d  = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = buf_valid;
        out_data  = buf_head.data;
        out_index = buf_head.idx;
        out_last  = buf_head.last;
        if (buf_valid && out_ready) begin
          buf_pop = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          acc_d   = acc_q ^ buf_head.data;
`endif
          if (buf_single) begin
            ptr_d = ptr_q + step[IDX_W-1:0];
            cnt_d = cnt_q - step;
            if (cnt_q != step) begin
              state_d = S_READ;
            end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      S_CSUM: begin
        out_valid = 1'b1;
        out_data  = acc_q;
        out_last  = 1'b1;
        if (out_ready) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign busy = state_q != S_IDLE;

endmodule

// File: tb/tb_regfile_dumper.sv
// Bench for regfile_dumper: table vectors, hand sequences, random dumps
// checked against a queue model of the expected word stream.
module tb_regfile_dumper;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [4:0]  first_index;
  logic [4:0]  last_index;
  logic        rd_en1;
  logic [4:0]  rd_index1;
  logic        rd_en2;
  logic [4:0]  rd_index2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  regfile_dumper dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .first_index (first_index),
    .last_index  (last_index),
    .rd_en1      (rd_en1),
    .rd_index1   (rd_index1),
    .rd_en2      (rd_en2),
    .rd_index2   (rd_index2),
    .rd_data1    (rd_data1),
    .rd_data2    (rd_data2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] regs [32];

  // Register file: data valid the cycle after enable, junk otherwise
  always @(posedge clk) begin
    rd_data1 <= rd_en1 ? regs[rd_index1] : $urandom();
    rd_data2 <= rd_en2 ? regs[rd_index2] : $urandom();
  end

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } word_t;

  typedef struct {
    logic [4:0] f;
    logic [4:0] l;
    int         mode;
    int         words;
  } vec_t;

  word_t exp_q[$];
  vec_t  tbl[6];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int words, done_cnt, rd1, rd2;
  int done_cyc, last_hs_cyc;
  int mode_r = 0;
  int stall_n;
  bit tog;
  bit mon_en = 0;
  bit stall_q = 0;
  logic [31:0] h_data;
  logic [4:0]  h_idx;
  logic        h_last;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    word_t e;
    cyc++;
    if (mon_en) begin
      case (mode_r)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom() % 2);
        default: begin
          if (out_valid && out_index == 5'd1 && stall_n < 5) begin
            out_ready = 1'b0;
            stall_n++;
          end else begin
            out_ready = tog;
            tog = !tog;
          end
        end
      endcase
      if (stall_q) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, h_data);
        chk("hold_index", 32'(out_index), 32'(h_idx));
        chk("hold_last", 32'(out_last), 32'(h_last));
      end
      stall_q = out_valid && !out_ready;
      h_data  = out_data;
      h_idx   = out_index;
      h_last  = out_last;
      if (out_valid && out_ready) begin
        words++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'(out_index), 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          chk("word_index", 32'(out_index), 32'(e.idx));
          chk("word_data", out_data, e.data);
          chk("word_last", 32'(out_last), 32'(e.last));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      rd1 += int'(rd_en1);
      rd2 += int'(rd_en2);
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic build_expect(input logic [4:0] f, input logic [4:0] l,
                              output int n);
    logic [31:0] acc;
    logic [4:0]  idx;
    n = int'(5'(l - f)) + 1;
    acc = '0;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      idx = 5'(int'(f) + k);
      exp_q.push_back('{idx, regs[idx], (CS == 0) && (k == n - 1)});
      acc = acc ^ regs[idx];
    end
    if (CS != 0) exp_q.push_back('{5'd0, acc, 1'b1});
  endtask

  task automatic run_dump(input logic [4:0] f, input logic [4:0] l,
                          input int mode, input int exp_words);
    int n, lat, t;
    build_expect(f, l, n);
    words = 0; done_cnt = 0; rd1 = 0; rd2 = 0;
    done_cyc = -10; last_hs_cyc = -10;
    mode_r = mode; stall_n = 0; tog = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    start = 1'b1; first_index = f; last_index = l;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == 0) begin
      chk("done_timeout", 32'(t), 32'd0);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    out_ready = 1'b1;
    chk("word_count", 32'(words), 32'(exp_words + CS));
    chk("words_left", 32'(exp_q.size()), 32'd0);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("done_after_last", 32'(done_cyc), 32'(last_hs_cyc + 1));
    chk("rd_en1_count", 32'(rd1), 32'((n + 1) / 2));
    chk("rd_en2_count", 32'(rd2), 32'(n / 2));
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_index"}, 32'(out_index), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rden"}, 32'({rd_en1, rd_en2}), 32'd0);
  endtask

  initial begin
    int t, n, bad;
    reset_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    first_index = '0; last_index = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    tbl[0] = '{5'd0,  5'd31, 0, 32};
    tbl[1] = '{5'd30, 5'd1,  0, 4};
    tbl[2] = '{5'd5,  5'd5,  0, 1};
    tbl[3] = '{5'd0,  5'd3,  2, 4};
    tbl[4] = '{5'd31, 5'd0,  1, 2};
    tbl[5] = '{5'd7,  5'd6,  1, 32};
    for (int i = 0; i < 6; i++)
      run_dump(tbl[i].f, tbl[i].l, tbl[i].mode, tbl[i].words);

    // Second start mid-dump is ignored; reset at the third word aborts
    build_expect(5'd0, 5'd31, n);
    words = 0; done_cnt = 0; mode_r = 0; mon_en = 1'b1;
    @(negedge clk);
    start = 1'b1; first_index = 5'd0; last_index = 5'd31;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; first_index = 5'd10; last_index = 5'd12;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!(out_valid && out_index == 5'd2) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("third_word_seen", 32'(out_index), 32'd2);
    reset_n = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    reset_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy || out_valid) bad++;
    end
    chk("quiet_after_abort", 32'(bad), 32'd0);
    chk("no_done_abort", 32'(done_cnt), 32'd0);
    exp_q.delete();

    for (int r = 0; r < 15; r++) begin
      logic [4:0] f, l;
      for (int i = 0; i < 32; i++) regs[i] = $urandom();
      f = 5'($urandom_range(0, 31));
      l = 5'($urandom_range(0, 31));
      run_dump(f, l, 1, int'(5'(l - f)) + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
